// File: rtl/spram_uart_rx_buffer_pkg.sv
// Shared types and constants for the double-banked SPRAM UART receive buffer.
package spram_uart_rx_buffer_pkg;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_LOAD, RD_HOLD} rd_state_t;

  localparam logic BANK_0 = 1'b0;
  localparam logic BANK_1 = 1'b1;

  // Each MASKWREN bit enables one nibble of the 16-bit SPRAM word.
  localparam logic [3:0] MASK_LO = 4'b0011;
  localparam logic [3:0] MASK_HI = 4'b1100;

  function automatic logic [3:0] lane_mask(input logic byte_sel);
    return byte_sel ? MASK_HI : MASK_LO;
  endfunction

endpackage

// File: rtl/sb_spram256ka.sv
// Behavioural 16K x 16 SB_SPRAM256KA model for simulation; the vendor cell is used under YOSYS.
`ifndef YOSYS
module SB_SPRAM256KA (
  input  logic [13:0] ADDRESS,
  input  logic [15:0] DATAIN,
  input  logic [3:0]  MASKWREN,
  input  logic        WREN,
  input  logic        CHIPSELECT,
  input  logic        CLOCK,
  input  logic        STANDBY,
  input  logic        SLEEP,
  input  logic        POWEROFF,
  output logic [15:0] DATAOUT
);
  logic [15:0] mem [0:16383];
  logic        active;

  // POWEROFF is active low on the real cell.
  assign active = CHIPSELECT && !STANDBY && !SLEEP && POWEROFF;

  always_ff @(posedge CLOCK) begin
    if (active) begin
      if (WREN) begin
        for (int n = 0; n < 4; n++) begin
          if (MASKWREN[n]) mem[ADDRESS][n*4 +: 4] <= DATAIN[n*4 +: 4];
        end
      end else begin
        DATAOUT <= mem[ADDRESS];
      end
    end
  end
endmodule
`endif

// File: rtl/spram_uart_rx_buffer_uart_rx.sv
// 8N1 serial receiver with a 2-flop synchronizer; exposes rx_idle when UART_RX_FLUSH_EN is defined.
module uart_rx
  import spram_uart_rx_buffer_pkg::*;
#(
  parameter logic [6:0] clock_divider = 7'd13
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_in,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_error
`ifdef UART_RX_FLUSH_EN
  ,
  output logic       rx_idle
`endif
);
  localparam logic [6:0] HALF = clock_divider >> 1;
  localparam logic [6:0] LAST = clock_divider - 7'd1;

  logic       sync1_q, sync2_q, prev_q;
  rx_state_t  state_q, state_d;
  logic [6:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d, data_q, data_d;
  logic       valid_q, valid_d, ferr_q, ferr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 7'd1;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = 7'd0;
        bit_d = 3'd0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        // A start bit that is high again at mid-bit was a glitch.
        if (cnt_q == HALF) begin
          cnt_d   = 7'd0;
          state_d = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == LAST) begin
          cnt_d   = 7'd0;
          shift_d = {sync2_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = 7'd0;
          state_d = RX_IDLE;
          if (sync2_q) begin
            valid_d = 1'b1;
            data_d  = shift_q;
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= 7'd0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data        = data_q;
  assign data_valid  = valid_q;
  assign frame_error = ferr_q;
`ifdef UART_RX_FLUSH_EN
  assign rx_idle     = (state_q == RX_IDLE);
`endif
endmodule

// File: rtl/spram_uart_rx_buffer.sv
// UART receiver feeding two ping-pong SPRAM banks; define UART_RX_FLUSH_EN to release partial banks after line idle.
module spram_uart_rx_buffer
  import spram_uart_rx_buffer_pkg::*;
#(
  parameter logic [6:0]  clock_divider = 7'd13,
  parameter logic [14:0] max_address   = 15'h3FFF,
  parameter int          idle_bits     = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       uart_rx,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       frame_error,
  output logic       overrun
);
  localparam logic [15:0] BANK_BYTES = {1'b0, max_address} + 16'd1;

  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        flush;

  logic        wr_bank_q, wr_bank_d;
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic        rd_busy_q, rd_busy_d;
  logic [15:0] rd_len_q, rd_len_d;
  logic [15:0] rd_addr_q, rd_addr_d;
  rd_state_t   rd_state_q, rd_state_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;

  logic        wr_full, swap, do_write, wr_target, rd_bank;
  logic [14:0] wr_byte_addr;
  logic        we0, we1, re0, re1;
  logic [13:0] addr0, addr1;
  logic [15:0] dout0, dout1, rd_word;

`ifdef UART_RX_FLUSH_EN
  logic rx_idle;
`endif

  uart_rx #(.clock_divider(clock_divider)) u_rx (
    .clock      (clock),
    .reset      (reset),
    .rx_in      (uart_rx),
    .data       (rx_data),
    .data_valid (rx_valid),
    .frame_error(frame_error)
`ifdef UART_RX_FLUSH_EN
    ,
    .rx_idle    (rx_idle)
`endif
  );

`ifdef UART_RX_FLUSH_EN
  localparam logic [15:0] IDLE_CYCLES = 16'(idle_bits * int'(clock_divider));
  logic [15:0] idle_cnt_q, idle_cnt_d;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (!rx_idle) idle_cnt_d = 16'd0;
    else if (idle_cnt_q != IDLE_CYCLES) idle_cnt_d = idle_cnt_q + 16'd1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) idle_cnt_q <= 16'd0;
    else       idle_cnt_q <= idle_cnt_d;
  end

  assign flush = (idle_cnt_q == IDLE_CYCLES) && (wr_cnt_q != 16'd0) && !rd_busy_q;
`else
  assign flush = 1'b0;
`endif

  // A byte arriving in the swap cycle lands at address 0 of the bank just freed.
  always_comb begin
    wr_full      = (wr_cnt_q == BANK_BYTES);
    swap         = !rd_busy_q && (wr_full || flush);
    do_write     = rx_valid && (swap || !wr_full);
    wr_target    = swap ? ~wr_bank_q : wr_bank_q;
    wr_byte_addr = swap ? 15'd0 : wr_cnt_q[14:0];
    rd_bank      = ~wr_bank_q;
  end

  assign we0   = do_write && (wr_target == BANK_0);
  assign we1   = do_write && (wr_target == BANK_1);
  assign re0   = (rd_state_q == RD_ISSUE) && (rd_bank == BANK_0);
  assign re1   = (rd_state_q == RD_ISSUE) && (rd_bank == BANK_1);
  assign addr0 = we0 ? wr_byte_addr[14:1] : rd_addr_q[14:1];
  assign addr1 = we1 ? wr_byte_addr[14:1] : rd_addr_q[14:1];

  SB_SPRAM256KA u_bank0 (
    .ADDRESS   (addr0),
    .DATAIN    ({rx_data, rx_data}),
    .MASKWREN  (lane_mask(wr_byte_addr[0])),
    .WREN      (we0),
    .CHIPSELECT(we0 | re0),
    .CLOCK     (clock),
    .STANDBY   (1'b0),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (dout0)
  );

  SB_SPRAM256KA u_bank1 (
    .ADDRESS   (addr1),
    .DATAIN    ({rx_data, rx_data}),
    .MASKWREN  (lane_mask(wr_byte_addr[0])),
    .WREN      (we1),
    .CHIPSELECT(we1 | re1),
    .CLOCK     (clock),
    .STANDBY   (1'b0),
    .SLEEP     (1'b0),
    .POWEROFF  (1'b1),
    .DATAOUT   (dout1)
  );

  assign rd_word = (rd_bank == BANK_1) ? dout1 : dout0;

  always_comb begin
    wr_bank_d  = wr_bank_q;
    wr_cnt_d   = wr_cnt_q;
    rd_busy_d  = rd_busy_q;
    rd_len_d   = rd_len_q;
    rd_addr_d  = rd_addr_q;
    rd_state_d = rd_state_q;
    data_out_d = data_out_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q | (rx_valid && !do_write);
    case (rd_state_q)
      RD_IDLE:  ;
      RD_ISSUE: rd_state_d = RD_LOAD;
      RD_LOAD: begin
        data_out_d = rd_addr_q[0] ? rd_word[15:8] : rd_word[7:0];
        valid_d    = 1'b1;
        rd_state_d = RD_HOLD;
      end
      RD_HOLD: begin
        if (data_out_ready) begin
          valid_d   = 1'b0;
          rd_addr_d = rd_addr_q + 16'd1;
          if (rd_addr_q + 16'd1 == rd_len_q) begin
            rd_busy_d  = 1'b0;
            rd_state_d = RD_IDLE;
          end else begin
            rd_state_d = RD_ISSUE;
          end
        end
      end
      default: rd_state_d = RD_IDLE;
    endcase
    if (swap) begin
      wr_bank_d  = ~wr_bank_q;
      wr_cnt_d   = do_write ? 16'd1 : 16'd0;
      rd_len_d   = wr_cnt_q;
      rd_addr_d  = 16'd0;
      rd_busy_d  = 1'b1;
      rd_state_d = RD_ISSUE;
    end else if (do_write) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_bank_q  <= BANK_0;
      wr_cnt_q   <= 16'd0;
      rd_busy_q  <= 1'b0;
      rd_len_q   <= 16'd0;
      rd_addr_q  <= 16'd0;
      rd_state_q <= RD_IDLE;
      data_out_q <= 8'h00;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      wr_bank_q  <= wr_bank_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_busy_q  <= rd_busy_d;
      rd_len_q   <= rd_len_d;
      rd_addr_q  <= rd_addr_d;
      rd_state_q <= rd_state_d;
      data_out_q <= data_out_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign overrun        = overrun_q;
endmodule

// File: tb/tb_spram_uart_rx_buffer.sv
// Scoreboard bench for spram_uart_rx_buffer with 4-byte banks; honours UART_RX_FLUSH_EN.
module tb_spram_uart_rx_buffer;
  localparam logic [6:0] DIV   = 7'd13;
  localparam int         DIV_I = 13;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_rx;
  logic       ready;
  logic [7:0] data_out;
  logic       valid;
  logic       frame_error;
  logic       overrun;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         fe_count = 0;
  int         rx_count = 0;
  logic       prev_accept = 1'b0;
  logic [7:0] exp_q[$];
  logic [7:0] t1_bytes [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};

  always #5 clk = ~clk;

  spram_uart_rx_buffer #(
    .clock_divider(DIV),
    .max_address  (15'h0003),
    .idle_bits    (16)
  ) dut (
    .clock         (clk),
    .reset         (rst),
    .uart_rx       (uart_rx),
    .data_out      (data_out),
    .data_out_valid(valid),
    .data_out_ready(ready),
    .frame_error   (frame_error),
    .overrun       (overrun)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      tick(DIV_I);
    end
    uart_rx = 1'b1;
    tick(2 * DIV_I);
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_complete", 16'(exp_q.size()), 16'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check({tag, "_data_out"}, {8'd0, data_out}, 16'h0000);
    check({tag, "_valid"}, {15'd0, valid}, 16'd0);
    check({tag, "_frame_error"}, {15'd0, frame_error}, 16'd0);
    check({tag, "_overrun"}, {15'd0, overrun}, 16'd0);
  endtask

  // Output monitor: pops the scoreboard on every accepted byte.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_accept = 1'b0;
      end else begin
        if (frame_error) fe_count++;
        if (prev_accept) check("gap_after_accept", {15'd0, valid}, 16'd0);
        prev_accept = 1'b0;
        if (valid && ready) begin
          check("byte_expected", 16'(exp_q.size() != 0), 16'd1);
          if (exp_q.size() != 0) check("data_out", {8'd0, data_out}, {8'd0, exp_q.pop_front()});
          rx_count++;
          prev_accept = 1'b1;
        end
      end
    end
  end

  initial begin
    int fe_before;
    int rx_before;
    logic [7:0] b;

    rst     = 1'b1;
    uart_rx = 1'b1;
    ready   = 1'b0;
    tick(3);
    check_reset_outputs("reset");
    tick(1);
    rst = 1'b0;
    tick(2 * DIV_I);

    // Four bytes fill one bank and stream out with ready held high.
    ready = 1'b1;
    foreach (t1_bytes[i]) begin
      exp_q.push_back(t1_bytes[i]);
      send_byte(t1_bytes[i], 1'b1);
    end
    wait_drain(200);
    check("t1_no_frame_error", 16'(fe_count), 16'd0);
    check("t1_no_overrun", {15'd0, overrun}, 16'd0);

    // Stop bit held low.
    fe_before = fe_count;
    send_byte(8'h55, 1'b0);
    check("t2_frame_error_pulses", 16'(fe_count - fe_before), 16'd1);

    // Short low glitch.
    fe_before = fe_count;
    rx_before = rx_count;
    uart_rx = 1'b0;
    tick(4);
    uart_rx = 1'b1;
    tick(3 * DIV_I);
    check("t3_glitch_no_error", 16'(fe_count - fe_before), 16'd0);
    check("t3_glitch_no_byte", 16'(rx_count - rx_before), 16'd0);

    // The next bank must hold exactly these four bytes, nothing from t2/t3.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
    wait_drain(200);
    check("t3_no_overrun", {15'd0, overrun}, 16'd0);

    // Both banks fill with ready low; the last four bytes are dropped.
    ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      b = 8'($urandom_range(1, 255));
      if (i < 8) exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
    @(negedge clk);
    check("t4_overrun", {15'd0, overrun}, 16'd1);
    check("t4_hold_valid", {15'd0, valid}, 16'd1);
    check("t4_hold_data", {8'd0, data_out}, {8'd0, exp_q[0]});
    tick(7);
    @(negedge clk);
    check("t4_stable_valid", {15'd0, valid}, 16'd1);
    check("t4_stable_data", {8'd0, data_out}, {8'd0, exp_q[0]});
    tick(1);
    rx_before = rx_count;
    ready = 1'b1;
    wait_drain(400);
    tick(20);
    check("t4_delivered_count", 16'(rx_count - rx_before), 16'd8);
    check("t4_no_extra_valid", {15'd0, valid}, 16'd0);

    // Reset in the middle of a frame's data bits.
    uart_rx = 1'b0;
    tick(5 * DIV_I);
    rst     = 1'b1;
    uart_rx = 1'b1;
    check_reset_outputs("midframe_reset");
    tick(1);
    rst = 1'b0;
    tick(2 * DIV_I);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_byte(b, 1'b1);
    end
    wait_drain(200);

    // Two bytes then a long idle line.
    rx_before = rx_count;
`ifdef UART_RX_FLUSH_EN
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
`endif
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
`ifdef UART_RX_FLUSH_EN
    wait_drain(16 * DIV_I + 200);
    check("t6_flushed_count", 16'(rx_count - rx_before), 16'd2);
`else
    tick(16 * DIV_I + 100);
    check("t6_no_flush", 16'(rx_count - rx_before), 16'd0);
`endif
    check("t6_no_frame_error", 16'(fe_count), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
